// File: rtl/panel_seq_pkg.sv
// panel_seq_pkg: shared types for the LCD panel power sequencer.
//   seq_state_e   - sequencer state encoding
//   seq_out_t     - per-state output pattern (vdd / lvds / led / ready)
//   PWM_BITS_DEF  - default backlight PWM resolution
//   max2()        - elaboration-time helper for counter sizing
//   state_outputs() - decodes a state into its output pattern
package panel_seq_pkg;

  localparam int PWM_BITS_DEF = 8;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_VDD_WAIT,
    ST_LVDS_WAIT,
    ST_RUN,
    ST_BL_OFF,
    ST_LVDS_OFF,
    ST_COOLDOWN
  } seq_state_e;

  typedef struct packed {
    logic vdd;
    logic lvds;
    logic led;
    logic rdy;
  } seq_out_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic seq_out_t state_outputs(input seq_state_e s);
    seq_out_t o;
    o = '0;
    unique case (s)
      ST_VDD_WAIT:  o.vdd = 1'b1;
      ST_LVDS_WAIT: begin o.vdd = 1'b1; o.lvds = 1'b1; end
      ST_RUN:       o = '{vdd: 1'b1, lvds: 1'b1, led: 1'b1, rdy: 1'b1};
      ST_BL_OFF:    begin o.vdd = 1'b1; o.lvds = 1'b1; end
      ST_LVDS_OFF:  o.vdd = 1'b1;
      default:      o = '0;   // OFF, COOLDOWN
    endcase
    return o;
  endfunction

endpackage

// File: rtl/panel_power_seq_bl_pwm.sv
// bl_pwm: backlight PWM generator.
//   clk, rst    - pixel clock, async active-high reset
//   led_en_nxt  - next-cycle backlight enable from the sequencer, so the
//                 registered led_pwm lines up with the registered led_en
//   brightness  - duty, sampled only when the period counter wraps
//   led_pwm     - registered PWM output
// A duty of all-ones gives a constant-high output rather than 255/256.
module bl_pwm
  import panel_seq_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                led_en_nxt,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                led_pwm
);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      duty    <= '0;
      led_pwm <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      // take the new duty only at the period boundary so a period is never split
      if (cnt == '1) duty <= brightness;
      led_pwm <= led_en_nxt && ((cnt < duty) || (duty == '1));
    end
  end

endmodule

// File: rtl/panel_power_seq.sv
// panel_power_seq: LCD panel power-up / power-down sequencer.
//   clk           - pixel clock (only clock)
//   rst           - async active-high reset
//   power_req     - level request to power the panel
//   mmcm_lckd     - LVDS clock generator lock
//   brightness    - backlight duty (used only with PANEL_SEQ_PWM_EN)
//   panel_vdd_en  - panel logic supply enable
//   lvds_en       - LVDS serializer / video enable
//   led_en        - backlight enable
//   led_pwm       - backlight PWM (equals led_en without PANEL_SEQ_PWM_EN)
//   ready         - high only in RUN
//   fault         - sticky: lock lost while LVDS was running
// Build option: define PANEL_SEQ_PWM_EN to include the bl_pwm dimmer.
// All outputs are registered from the next-state decode, so they change
// on the same edge as the state register.
module panel_power_seq
  import panel_seq_pkg::*;
#(
  parameter int T_VDD_LVDS = 7200,
  parameter int T_LVDS_BL  = 14400,
  parameter int T_BL_LVDS  = 14400,
  parameter int T_LVDS_VDD = 7200,
  parameter int T_OFF_MIN  = 72000,
  parameter int PWM_BITS   = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                power_req,
  input  logic                mmcm_lckd,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                panel_vdd_en,
  output logic                lvds_en,
  output logic                led_en,
  output logic                led_pwm,
  output logic                ready,
  output logic                fault
);

  localparam int T_MAX = max2(max2(max2(T_VDD_LVDS, T_LVDS_BL), max2(T_BL_LVDS, T_LVDS_VDD)),
                              T_OFF_MIN);
  localparam int CW = $clog2(T_MAX) + 1;

  // timers load T-1 on entry and leave the state on the cycle they read zero
  localparam logic [CW-1:0] LD_VDD_LVDS = CW'(T_VDD_LVDS - 1);
  localparam logic [CW-1:0] LD_LVDS_BL  = CW'(T_LVDS_BL  - 1);
  localparam logic [CW-1:0] LD_BL_LVDS  = CW'(T_BL_LVDS  - 1);
  localparam logic [CW-1:0] LD_LVDS_VDD = CW'(T_LVDS_VDD - 1);
  localparam logic [CW-1:0] LD_OFF_MIN  = CW'(T_OFF_MIN  - 1);

  seq_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          fault_n;
  logic          abort, expired;
  seq_out_t      outs_n;

  assign abort   = !power_req || !mmcm_lckd;
  assign expired = (cnt == '0);
  assign outs_n  = state_outputs(state_n);

  always_comb begin
    state_n = state;
    cnt_n   = expired ? '0 : cnt - 1'b1;   // saturate at zero, never wrap
    unique case (state)
      ST_OFF:
        if (power_req && mmcm_lckd && !fault) begin
          state_n = ST_VDD_WAIT; cnt_n = LD_VDD_LVDS;
        end
      // abort is tested first so it wins over a timer expiring on the same edge
      ST_VDD_WAIT:
        if (abort) begin
          state_n = ST_COOLDOWN; cnt_n = LD_OFF_MIN;
        end else if (expired) begin
          state_n = ST_LVDS_WAIT; cnt_n = LD_LVDS_BL;
        end
      ST_LVDS_WAIT:
        if (abort) begin
          state_n = ST_LVDS_OFF; cnt_n = LD_LVDS_VDD;
        end else if (expired) begin
          state_n = ST_RUN;
        end
      ST_RUN:
        if (abort) begin
          state_n = ST_BL_OFF; cnt_n = LD_BL_LVDS;
        end
      // shutdown states ignore power_req / lock and always run to completion
      ST_BL_OFF:
        if (expired) begin
          state_n = ST_LVDS_OFF; cnt_n = LD_LVDS_VDD;
        end
      ST_LVDS_OFF:
        if (expired) begin
          state_n = ST_COOLDOWN; cnt_n = LD_OFF_MIN;
        end
      ST_COOLDOWN:
        if (expired) state_n = ST_OFF;
      default: begin
        state_n = ST_OFF; cnt_n = '0;
      end
    endcase
  end

  // fault can only be released once the request is withdrawn in OFF, so a
  // held request cannot silently restart into a lock-loss loop
  always_comb begin
    fault_n = fault;
    if (state == ST_OFF && !power_req) fault_n = 1'b0;
    if (lvds_en && !mmcm_lckd)         fault_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_OFF;
      cnt          <= '0;
      fault        <= 1'b0;
      panel_vdd_en <= 1'b0;
      lvds_en      <= 1'b0;
      led_en       <= 1'b0;
      ready        <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      fault        <= fault_n;
      panel_vdd_en <= outs_n.vdd;
      lvds_en      <= outs_n.lvds;
      led_en       <= outs_n.led;
      ready        <= outs_n.rdy;
    end
  end

`ifdef PANEL_SEQ_PWM_EN
  bl_pwm #(.PWM_BITS(PWM_BITS)) u_bl_pwm (
    .clk        (clk),
    .rst        (rst),
    .led_en_nxt (outs_n.led),
    .brightness (brightness),
    .led_pwm    (led_pwm)
  );
`else
  assign led_pwm = led_en;
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

endmodule

// File: tb/tb_panel_power_seq.sv
// tb_panel_power_seq: table-driven check of panel_power_seq with short timers.
// Each table row drives {power_req, mmcm_lckd} for n cycles; its expected
// {vdd, lvds, led_en, ready, fault} goes onto a scoreboard queue when the row
// is driven and is popped and compared once the cycles have elapsed.
module tb_panel_power_seq;

  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          power_req, mmcm_lckd;
  logic [PB-1:0] brightness;
  logic          panel_vdd_en, lvds_en, led_en, led_pwm, ready, fault;

  panel_power_seq #(
    .T_VDD_LVDS(10), .T_LVDS_BL(20), .T_BL_LVDS(20), .T_LVDS_VDD(10),
    .T_OFF_MIN(50), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .rst(rst), .power_req(power_req), .mmcm_lckd(mmcm_lckd),
    .brightness(brightness), .panel_vdd_en(panel_vdd_en), .lvds_en(lvds_en),
    .led_en(led_en), .led_pwm(led_pwm), .ready(ready), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pr;
    logic       lk;
    int         n;
    logic [4:0] exp;   // {vdd, lvds, led_en, ready, fault}
  } vec_t;

  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] V  = 5'b10000;
  localparam logic [4:0] VL = 5'b11000;
  localparam logic [4:0] RN = 5'b11110;
  localparam logic [4:0] F  = 5'b00001;

  vec_t       tbl[$];
  logic [4:0] sb_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic add(input logic pr, input logic lk, input int n, input logic [4:0] e);
    vec_t v;
    v.pr = pr; v.lk = lk; v.n = n; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {panel_vdd_en, lvds_en, led_en, ready, fault};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] e;
    int         hi, mism, found;
    logic       prev;

    // power-up from reset (no cooldown owed after reset)
    add(1,1,1,V);  add(1,1,9,V);  add(1,1,1,VL); add(1,1,19,VL); add(1,1,1,RN); add(1,1,5,RN);
    // normal shutdown; request at cycle 40 ignored until OFF at 81
    add(0,1,1,VL); add(0,1,19,VL); add(0,1,1,V);  add(0,1,9,V);   add(0,1,1,Z);  add(0,1,8,Z);
    add(1,1,1,Z);  add(1,1,40,Z);  add(1,1,1,Z);  add(1,1,1,V);
    // request drop mid LVDS_WAIT: straight to LVDS_OFF, backlight never on
    add(1,1,9,V);  add(1,1,1,VL); add(1,1,5,VL);  add(0,1,1,V);  add(0,1,9,V);   add(0,1,1,Z);
    add(0,1,49,Z); add(0,1,1,Z);  add(1,0,3,Z);   add(1,1,1,V);
    // request drop in VDD_WAIT: straight to COOLDOWN, re-request ignored
    add(1,1,3,V);  add(0,1,1,Z);  add(1,1,49,Z);  add(1,1,1,Z);  add(1,1,1,V);
    // abort on the last LVDS_WAIT cycle beats the timer
    add(1,1,9,V);  add(1,1,1,VL); add(1,1,19,VL); add(0,1,1,V);  add(0,1,9,V);   add(0,1,1,Z);
    add(0,1,49,Z); add(0,1,1,Z);  add(1,1,1,V);
    // abort on the last VDD_WAIT cycle beats the timer
    add(1,1,9,V);  add(0,1,1,Z);  add(0,1,49,Z); add(0,1,1,Z);  add(1,1,1,V);
    // lock loss in RUN: fault, full shutdown, no restart until request drops
    add(1,1,9,V);  add(1,1,1,VL); add(1,1,19,VL); add(1,1,1,RN); add(1,1,3,RN);
    add(1,0,1,VL|F); add(1,1,19,VL|F); add(1,1,1,V|F); add(1,1,9,V|F); add(1,1,1,F);
    add(1,1,49,F); add(1,1,1,F); add(1,1,5,F);    add(0,1,1,Z);  add(1,1,1,V);
    add(1,1,9,V);  add(1,1,1,VL); add(1,1,4,VL);

    rst = 1'b1; power_req = 1'b0; mmcm_lckd = 1'b1; brightness = 8'd64;
    repeat (3) @(negedge clk);
    chk("reset_outs", {outs(), led_pwm}, 6'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      power_req = tbl[i].pr;
      mmcm_lckd = tbl[i].lk;
      sb_q.push_back(tbl[i].exp);
      repeat (tbl[i].n) @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("row%0d", i), outs(), e);
`ifndef PANEL_SEQ_PWM_EN
      chk($sformatf("row%0d_pwm", i), led_pwm, e[2]);
`endif
    end

    // async reset while in LVDS_WAIT: outputs drop before any clock edge
    #2 rst = 1'b1;
    #1 chk("async_rst_outs", {outs(), led_pwm}, 6'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_restart", outs(), V);
    repeat (30) @(negedge clk);
    chk("post_rst_run", outs(), RN);

`ifdef PANEL_SEQ_PWM_EN
    repeat (300) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin hi += int'(led_pwm); @(negedge clk); end
    chk("pwm_duty_64", hi, 64);

    brightness = 8'd255;
    repeat (300) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin hi += int'(led_pwm); @(negedge clk); end
    chk("pwm_duty_255", hi, 256);

    brightness = 8'd64;
    repeat (300) @(negedge clk);
    found = 0;
    prev  = led_pwm;
    for (int i = 0; i < 600 && found == 0; i++) begin
      @(negedge clk);
      if (!prev && led_pwm) found = 1;
      prev = led_pwm;
    end
    chk("pwm_period_start_seen", found, 1);
    // now at period position 0; change duty at position 10
    repeat (10) @(negedge clk);
    brightness = 8'd128;
    hi = 0;
    for (int i = 10; i < 256; i++) begin hi += int'(led_pwm); @(negedge clk); end
    chk("pwm_old_duty_until_wrap", hi, 54);
    hi = 0;
    for (int i = 0; i < 256; i++) begin hi += int'(led_pwm); @(negedge clk); end
    chk("pwm_new_duty_after_wrap", hi, 128);
`else
    mism = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) power_req = 1'b0;
      if (led_pwm !== led_en) mism++;
      @(negedge clk);
    end
    chk("pwm_follows_led_en", mism, 0);
    chk("led_off_after_drop", led_en, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
